// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
//
// Small instruction queue between the fetch and decode stages. Fetch sends
// instructions with a toggle handshake. Each transition on triggerIn offers a
// new {dataIn, pcIn} pair. The buffer answers with one transition on ackOut
// once it has taken the pair. Decode drains the head entry with a
// valid/ready handshake. A one-cycle flushIn pulse (taken branch) discards
// every stored entry.
//
// Parameters
//   DEPTH      number of entries, power of two in the range 2..16
//
// Ports
//   clk        rising-edge clock for all state
//   rstN       asynchronous active-low reset
//   triggerIn  request toggle from fetch (asynchronous to us, so synchronised)
//   dataIn     instruction word, stable until ackOut toggles
//   pcIn       address of dataIn, stable until ackOut toggles
//   ackOut     acknowledge toggle back to fetch
//   instrOut   head-entry instruction (0 when empty)
//   pcOut      head-entry PC (0 when empty)
//   condOut    ARM condition field of the head instruction
//   validOut   head entry is valid
//   readyIn    decode accepts the head entry
//   flushIn    synchronous discard of all entries
//   countOut   number of stored entries
//   fullOut    countOut == DEPTH
//   emptyOut   countOut == 0
// ----------------------------------------------------------------------------
module fetch_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     triggerIn,
   input  logic [31:0]              dataIn,
   input  logic [31:0]              pcIn,
   output logic                     ackOut,
   output logic [31:0]              instrOut,
   output logic [31:0]              pcOut,
   output logic [3:0]               condOut,
   output logic                     validOut,
   input  logic                     readyIn,
   input  logic                     flushIn,
   output logic [$clog2(DEPTH):0]   countOut,
   output logic                     fullOut,
   output logic                     emptyOut
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   // Handshake synchroniser and acknowledge state
   logic          s1Q;
   logic          s2Q;
   logic          s3Q;
   logic          s3D;
   logic          ackQ;
   logic          ackD;

   // Queue bookkeeping
   logic [AW-1:0] wrPtrQ;
   logic [AW-1:0] wrPtrD;
   logic [AW-1:0] rdPtrQ;
   logic [AW-1:0] rdPtrD;
   logic [CW-1:0] countQ;
   logic [CW-1:0] countD;

   // Entry storage, instruction in the upper half and PC in the lower half
   logic [63:0]   mem [DEPTH];
   logic [63:0]   headEntry;

   logic          pending;
   logic          validInt;
   logic          pushEn;
   logic          popEn;

   // Next-state logic. A request is pending while the synchronised trigger
   // level differs from the last accepted level (s3). Flush wins over any
   // push or pop. It still acknowledges a pending request so that fetch is
   // not left waiting, but the data of that request is dropped.
   always_comb begin
      pending  = s2Q ^ s3Q;
      validInt = (countQ != '0);
      popEn    = validInt & readyIn & ~flushIn;
      // A pop on the same edge frees a slot, so a full buffer can still push.
      pushEn   = pending & ~flushIn & ((countQ != FULL_COUNT) | popEn);

      s3D    = s3Q;
      ackD   = ackQ;
      wrPtrD = wrPtrQ;
      rdPtrD = rdPtrQ;
      countD = countQ;

      if (flushIn) begin
         wrPtrD = '0;
         rdPtrD = '0;
         countD = '0;
         if (pending) begin
            s3D  = s2Q;
            ackD = ~ackQ;
         end
      end else begin
         if (pushEn) begin
            // The pointer width equals log2(DEPTH), so it wraps by overflow.
            wrPtrD = wrPtrQ + AW'(1);
            s3D    = s2Q;
            ackD   = ~ackQ;
         end
         if (popEn) begin
            rdPtrD = rdPtrQ + AW'(1);
         end
         case ({pushEn, popEn})
            2'b10:   countD = countQ + CW'(1);
            2'b01:   countD = countQ - CW'(1);
            default: countD = countQ;
         endcase
      end
   end

   // Control registers. triggerIn passes through two synchroniser flops
   // before it is compared with the accepted level. With space available,
   // this gives a fixed push latency of three edges.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         s1Q    <= 1'b0;
         s2Q    <= 1'b0;
         s3Q    <= 1'b0;
         ackQ   <= 1'b0;
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         countQ <= '0;
      end else begin
         s1Q    <= triggerIn;
         s2Q    <= s1Q;
         s3Q    <= s3D;
         ackQ   <= ackD;
         wrPtrQ <= wrPtrD;
         rdPtrQ <= rdPtrD;
         countQ <= countD;
      end
   end

   // Storage is not reset. Only entries inside the count window are ever
   // shown on the outputs.
   always_ff @(posedge clk) begin
      if (pushEn) begin
         mem[wrPtrQ] <= {dataIn, pcIn};
      end
   end

   // The head entry is masked to zero while empty. This keeps stale
   // storage off the outputs after reset or flush.
   always_comb begin
      headEntry = mem[rdPtrQ];
      instrOut  = validInt ? headEntry[63:32] : 32'h0;
      pcOut     = validInt ? headEntry[31:0]  : 32'h0;
      condOut   = instrOut[31:28];
      validOut  = validInt;
      ackOut    = ackQ;
      countOut  = countQ;
      fullOut   = (countQ == FULL_COUNT);
      emptyOut  = (countQ == '0);
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_fetch_buffer
//
// Directed testbench for fetch_buffer with DEPTH = 4. Each scenario task
// drives its own stimulus and compares the DUT outputs with hand-computed
// values.
// ----------------------------------------------------------------------------
module tb_fetch_buffer;

   logic        clk;
   logic        rstN;
   logic        triggerIn;
   logic [31:0] dataIn;
   logic [31:0] pcIn;
   logic        ackOut;
   logic [31:0] instrOut;
   logic [31:0] pcOut;
   logic [3:0]  condOut;
   logic        validOut;
   logic        readyIn;
   logic        flushIn;
   logic [2:0]  countOut;
   logic        fullOut;
   logic        emptyOut;

   int          nCompared;
   int          nMismatched;
   logic        expAck;

   fetch_buffer #(.DEPTH(4)) dut (
      .clk       (clk),
      .rstN      (rstN),
      .triggerIn (triggerIn),
      .dataIn    (dataIn),
      .pcIn      (pcIn),
      .ackOut    (ackOut),
      .instrOut  (instrOut),
      .pcOut     (pcOut),
      .condOut   (condOut),
      .validOut  (validOut),
      .readyIn   (readyIn),
      .flushIn   (flushIn),
      .countOut  (countOut),
      .fullOut   (fullOut),
      .emptyOut  (emptyOut)
   );

   // Free-running clock with rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word to the DUT and wait, with a bound, for the ackOut toggle.
   // cycles is set to the number of edges taken, or -1 on timeout.
   task automatic sendWord(input logic [31:0] data, input logic [31:0] pc,
                           output int cycles);
      logic startAck;
      startAck  = ackOut;
      dataIn    = data;
      pcIn      = pc;
      triggerIn = ~triggerIn;
      cycles    = -1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (ackOut !== startAck) begin
            cycles = k;
            break;
         end
      end
   endtask

   // Reset state with the clock running
   task automatic test_reset();
      rstN      = 1'b0;
      triggerIn = 1'b0;
      dataIn    = 32'h0;
      pcIn      = 32'h0;
      readyIn   = 1'b0;
      flushIn   = 1'b0;
      expAck    = 1'b0;
      #12;
      nCompared++;
      if (validOut !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_valid got %b want 0", validOut);
      end
      nCompared++;
      if (emptyOut !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL reset_empty got %b want 1", emptyOut);
      end
      nCompared++;
      if (fullOut !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_full got %b want 0", fullOut);
      end
      nCompared++;
      if (countOut !== 3'd0 || ackOut !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_count_ack got %0d/%b want 0/0", countOut, ackOut);
      end
      nCompared++;
      if (instrOut !== 32'h0 || pcOut !== 32'h0 || condOut !== 4'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_head got %h/%h/%h want 0/0/0", instrOut, pcOut, condOut);
      end
      rstN = 1'b1;
      tick();
   endtask

   // Single push: ack on the third edge, and the head shows the new word
   task automatic test_single_push();
      readyIn   = 1'b0;
      dataIn    = 32'hE3A01005;
      pcIn      = 32'h0;
      triggerIn = ~triggerIn;
      tick();
      tick();
      nCompared++;
      if (ackOut !== expAck) begin
         nMismatched++;
         $display("[TB] FAIL single_early_ack got %b want %b", ackOut, expAck);
      end
      tick();
      expAck = ~expAck;
      nCompared++;
      if (ackOut !== expAck) begin
         nMismatched++;
         $display("[TB] FAIL single_ack got %b want %b", ackOut, expAck);
      end
      nCompared++;
      if (validOut !== 1'b1 || countOut !== 3'd1) begin
         nMismatched++;
         $display("[TB] FAIL single_valid got %b/%0d want 1/1", validOut, countOut);
      end
      nCompared++;
      if (condOut !== 4'hE || pcOut !== 32'h0 || instrOut !== 32'hE3A01005) begin
         nMismatched++;
         $display("[TB] FAIL single_head got %h/%h/%h want e/0/e3a01005", condOut, pcOut, instrOut);
      end
      readyIn = 1'b1;
      tick();
      readyIn = 1'b0;
      nCompared++;
      if (emptyOut !== 1'b1 || instrOut !== 32'h0) begin
         nMismatched++;
         $display("[TB] FAIL single_pop got %b/%h want 1/0", emptyOut, instrOut);
      end
   endtask

   // Fill to full, stall the 5th request, then pop and push on one edge
   task automatic test_fill_full();
      int          cycles;
      logic [31:0] expPc [4];
      expPc[0] = 32'h44;
      expPc[1] = 32'h48;
      expPc[2] = 32'h4C;
      expPc[3] = 32'h50;
      readyIn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sendWord(32'h1000_0040 + 32'(4 * i), 32'h40 + 32'(4 * i), cycles);
         expAck = ~expAck;
         nCompared++;
         if (cycles !== 3) begin
            nMismatched++;
            $display("[TB] FAIL fill_latency%0d got %0d want 3", i, cycles);
         end
      end
      nCompared++;
      if (fullOut !== 1'b1 || countOut !== 3'd4) begin
         nMismatched++;
         $display("[TB] FAIL fill_full got %b/%0d want 1/4", fullOut, countOut);
      end
      dataIn    = 32'h1000_0050;
      pcIn      = 32'h50;
      triggerIn = ~triggerIn;
      for (int i = 0; i < 5; i++) tick();
      nCompared++;
      if (ackOut !== expAck || countOut !== 3'd4) begin
         nMismatched++;
         $display("[TB] FAIL fill_stall got %b/%0d want %b/4", ackOut, countOut, expAck);
      end
      readyIn = 1'b1;
      tick();
      readyIn = 1'b0;
      expAck  = ~expAck;
      nCompared++;
      if (ackOut !== expAck || countOut !== 3'd4 || fullOut !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL fill_swap got %b/%0d/%b want %b/4/1", ackOut, countOut, fullOut, expAck);
      end
      readyIn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nCompared++;
         if (pcOut !== expPc[i] || instrOut !== (32'h1000_0000 | expPc[i])) begin
            nMismatched++;
            $display("[TB] FAIL fill_drain%0d got %h/%h want %h/%h", i, pcOut, instrOut,
                     expPc[i], 32'h1000_0000 | expPc[i]);
         end
         tick();
      end
      readyIn = 1'b0;
      nCompared++;
      if (emptyOut !== 1'b1 || countOut !== 3'd0) begin
         nMismatched++;
         $display("[TB] FAIL fill_empty got %b/%0d want 1/0", emptyOut, countOut);
      end
   endtask

   // Ten pushes while decode is always ready, wrapping the pointers twice
   task automatic test_wrap_order();
      int cycles;
      readyIn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sendWord(32'hA000_0000 + 32'(i), 32'(4 * i), cycles);
         expAck = ~expAck;
         nCompared++;
         if (cycles !== 3 || validOut !== 1'b1 || pcOut !== 32'(4 * i) ||
             instrOut !== 32'hA000_0000 + 32'(i) || countOut !== 3'd1) begin
            nMismatched++;
            $display("[TB] FAIL wrap%0d got cyc=%0d v=%b pc=%h in=%h cnt=%0d want cyc=3 v=1 pc=%h in=%h cnt=1",
                     i, cycles, validOut, pcOut, instrOut, countOut, 4 * i, 32'hA000_0000 + 32'(i));
         end
      end
      tick();
      readyIn = 1'b0;
      nCompared++;
      if (emptyOut !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL wrap_empty got %b want 1", emptyOut);
      end
   endtask

   // Flush with three entries stored and one request pending
   task automatic test_flush();
      int cycles;
      readyIn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sendWord(32'hB000_0000 + 32'(i), 32'h200 + 32'(4 * i), cycles);
         expAck = ~expAck;
      end
      nCompared++;
      if (countOut !== 3'd3) begin
         nMismatched++;
         $display("[TB] FAIL flush_pre got %0d want 3", countOut);
      end
      dataIn    = 32'hBBBB_BBBB;
      pcIn      = 32'h20C;
      triggerIn = ~triggerIn;
      tick();
      tick();
      flushIn = 1'b1;
      tick();
      flushIn = 1'b0;
      expAck  = ~expAck;
      nCompared++;
      if (ackOut !== expAck || countOut !== 3'd0 || validOut !== 1'b0 || emptyOut !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL flush got ack=%b cnt=%0d v=%b e=%b want ack=%b cnt=0 v=0 e=1",
                  ackOut, countOut, validOut, emptyOut, expAck);
      end
      for (int i = 0; i < 5; i++) tick();
      nCompared++;
      if (ackOut !== expAck || countOut !== 3'd0 || validOut !== 1'b0 || instrOut !== 32'h0) begin
         nMismatched++;
         $display("[TB] FAIL flush_after got ack=%b cnt=%0d v=%b in=%h want ack=%b cnt=0 v=0 in=0",
                  ackOut, countOut, validOut, instrOut, expAck);
      end
   endtask

   // Push and pop on the same edge with one entry stored
   task automatic test_back_to_back();
      int cycles;
      readyIn = 1'b0;
      sendWord(32'h1111_1111, 32'h300, cycles);
      expAck = ~expAck;
      dataIn    = 32'h2222_2222;
      pcIn      = 32'h304;
      triggerIn = ~triggerIn;
      tick();
      tick();
      readyIn = 1'b1;
      tick();
      readyIn = 1'b0;
      expAck  = ~expAck;
      nCompared++;
      if (countOut !== 3'd1 || instrOut !== 32'h2222_2222 || pcOut !== 32'h304 || ackOut !== expAck) begin
         nMismatched++;
         $display("[TB] FAIL b2b got cnt=%0d in=%h pc=%h ack=%b want cnt=1 in=22222222 pc=304 ack=%b",
                  countOut, instrOut, pcOut, ackOut, expAck);
      end
      nCompared++;
      if (condOut !== 4'h2) begin
         nMismatched++;
         $display("[TB] FAIL b2b_cond got %h want 2", condOut);
      end
      readyIn = 1'b1;
      tick();
      readyIn = 1'b0;
   endtask

   // Asynchronous reset with two entries stored, then a clean new request
   task automatic test_reset_mid();
      int cycles;
      readyIn = 1'b0;
      sendWord(32'hC000_0001, 32'h400, cycles);
      sendWord(32'hC000_0002, 32'h404, cycles);
      nCompared++;
      if (countOut !== 3'd2) begin
         nMismatched++;
         $display("[TB] FAIL rstmid_pre got %0d want 2", countOut);
      end
      #2;
      rstN      = 1'b0;
      triggerIn = 1'b0;
      #1;
      nCompared++;
      if (validOut !== 1'b0 || emptyOut !== 1'b1 || countOut !== 3'd0 || ackOut !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL rstmid_ctl got v=%b e=%b cnt=%0d ack=%b want 0/1/0/0",
                  validOut, emptyOut, countOut, ackOut);
      end
      nCompared++;
      if (instrOut !== 32'h0 || pcOut !== 32'h0 || condOut !== 4'h0) begin
         nMismatched++;
         $display("[TB] FAIL rstmid_head got %h/%h/%h want 0/0/0", instrOut, pcOut, condOut);
      end
      tick();
      rstN   = 1'b1;
      expAck = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      nCompared++;
      if (ackOut !== expAck || countOut !== 3'd0) begin
         nMismatched++;
         $display("[TB] FAIL rstmid_idle got %b/%0d want %b/0", ackOut, countOut, expAck);
      end
      sendWord(32'hD000_0000, 32'h500, cycles);
      expAck = ~expAck;
      nCompared++;
      if (cycles !== 3 || pcOut !== 32'h500 || countOut !== 3'd1 || ackOut !== expAck) begin
         nMismatched++;
         $display("[TB] FAIL rstmid_new got cyc=%0d pc=%h cnt=%0d ack=%b want 3/500/1/%b",
                  cycles, pcOut, countOut, ackOut, expAck);
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      nCompared   = 0;
      nMismatched = 0;
      test_reset();
      test_single_push();
      test_fill_full();
      test_wrap_order();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
